// File: rtl/snn_ff_pkg.sv
// ---------------------------------------------------------------------------
// snn_ff_pkg
// Definitions shared by the feed-forward SNN output path:
//   - AER tag values that separate spike events from time-step markers
//   - state encoding of the AER 4-phase transmit FSM
// ---------------------------------------------------------------------------
package snn_ff_pkg;

    localparam logic AER_TAG_SPIKE = 1'b0;
    localparam logic AER_TAG_STEP  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_ACK_LO = 2'd2
    } aer_state_t;

endpackage

// File: rtl/aer_spike_encoder_if.sv
// ---------------------------------------------------------------------------
// aer_spike_encoder_if
// Off-core AER link carrying one event per 4-phase REQ/ACK handshake.
//   AERout_ADDR  event address (spike: neuron index, marker: time step)
//   AERout_TAG   0 = spike, 1 = time-step marker
//   AERout_REQ   request, driven by the sender
//   AERout_ACK   acknowledge, driven by the receiver (asynchronous domain)
// Modports: master = event sender, slave = event receiver.
// ---------------------------------------------------------------------------
interface aer_spike_encoder_if #(
    parameter int AER_OUT_WIDTH = 12
);
    logic [AER_OUT_WIDTH-1:0] AERout_ADDR;
    logic                     AERout_TAG;
    logic                     AERout_REQ;
    logic                     AERout_ACK;

    modport master (
        output AERout_ADDR,
        output AERout_TAG,
        output AERout_REQ,
        input  AERout_ACK
    );

    modport slave (
        input  AERout_ADDR,
        input  AERout_TAG,
        input  AERout_REQ,
        output AERout_ACK
    );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty flags. Pointers carry one
// extra MSB so full and empty are told apart without a separate counter.
// The head entry is presented combinationally on rdata while not empty.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored while full)
//   pop             remove head entry (ignored while empty)
//   rdata           head entry
//   full, empty     registered status flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_next, rd_next;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    // Flags are computed from the next pointers so they are registered yet
    // change on the same edge as the occupancy.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= (wr_next == rd_next);
            full   <= (wr_next[AW] != rd_next[AW]) &&
                      (wr_next[AW-1:0] == rd_next[AW-1:0]);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries
    // are valid, and a reset-free array maps onto plain RAM/register files.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aer_spike_encoder.sv
// ---------------------------------------------------------------------------
// aer_spike_encoder
// Captures spikes from the neuron update datapath during a time-step sweep,
// appends a time-step marker when the sweep closes, buffers both in a FIFO
// and transmits them off-core over a 4-phase AER handshake.
// Ports:
//   CLK, RSTN           clock, asynchronous active-low reset
//   spike_in            spike of the neuron evaluated this cycle
//   spike_valid         qualifies spike_in / post_neur_addr
//   post_neur_addr      index of the neuron evaluated this cycle
//   step_done           pulse closing a time-step sweep
//   current_time_step   time step being closed by step_done
//   time_ref_event      sample boundary; clears overflow and drop_cnt
//   aer                 AER output link (master side)
//   fifo_full           event buffer holds FIFO_DEPTH entries
//   overflow            sticky: an event was dropped since the last clear
//   drop_cnt            saturating count of dropped events
// ---------------------------------------------------------------------------
module aer_spike_encoder
    import snn_ff_pkg::*;
#(
    parameter int TIME_STEP      = 8,
    parameter int AER_OUT_WIDTH  = 12,
    parameter int FIFO_DEPTH     = 16,
    parameter int DROP_CNT_WIDTH = 8,
    localparam int TS_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      spike_in,
    input  logic                      spike_valid,
    input  logic [AER_OUT_WIDTH-1:0]  post_neur_addr,
    input  logic                      step_done,
    input  logic [TS_W-1:0]           current_time_step,
    input  logic                      time_ref_event,
    aer_spike_encoder_if.master       aer,
    output logic                      fifo_full,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    localparam int EW  = AER_OUT_WIDTH + 1;
    localparam int DW1 = DROP_CNT_WIDTH + 1;

    // ---------------- push arbitration ----------------
    logic            spike_push;
    logic            push_req;
    logic [EW-1:0]   push_data;
    logic            pend;
    logic [TS_W-1:0] pend_ts;
    logic            pend_set, pend_clr;
    logic            step_drop, fifo_drop;

    assign spike_push = spike_valid & spike_in;

    // Priority: spike, then a held marker, then a fresh marker. A marker that
    // loses to a spike waits in the single pending slot; any step_done that
    // arrives while the slot is occupied is lost.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        step_drop = 1'b0;
        if (spike_push) begin
            push_req  = 1'b1;
            push_data = {AER_TAG_SPIKE, post_neur_addr};
            if (step_done) begin
                if (pend) step_drop = 1'b1;
                else      pend_set  = 1'b1;
            end
        end else if (pend) begin
            push_req  = 1'b1;
            push_data = {AER_TAG_STEP, AER_OUT_WIDTH'(pend_ts)};
            pend_clr  = 1'b1;
            step_drop = step_done;
        end else if (step_done) begin
            push_req  = 1'b1;
            push_data = {AER_TAG_STEP, AER_OUT_WIDTH'(current_time_step)};
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend    <= 1'b0;
            pend_ts <= '0;
        end else if (pend_set) begin
            pend    <= 1'b1;
            pend_ts <= current_time_step;
        end else if (pend_clr) begin
            pend    <= 1'b0;
        end
    end

    // A push against a full FIFO is lost even if the head pops this cycle.
    assign fifo_drop = push_req & fifo_full;

    // ---------------- event buffer ----------------
    logic          fifo_empty, fifo_pop;
    logic [EW-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (push_req),
        .wdata (push_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- drop status ----------------
    logic [1:0]                n_drops;
    logic [DROP_CNT_WIDTH-1:0] drop_base, drop_next;
    logic [DW1-1:0]            drop_sum;

    // A clear and a drop in the same cycle leave the drop recorded.
    assign n_drops   = {1'b0, fifo_drop} + {1'b0, step_drop};
    assign drop_base = time_ref_event ? '0 : drop_cnt;
    assign drop_sum  = {1'b0, drop_base} + DW1'(n_drops);
    assign drop_next = drop_sum[DW1-1] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= (n_drops != 2'd0) | (overflow & ~time_ref_event);
            drop_cnt <= drop_next;
        end
    end

    // ---------------- ACK synchronizer ----------------
    logic ack_meta, ack_s;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= aer.AERout_ACK;
            ack_s    <= ack_meta;
        end
    end

    // ---------------- 4-phase transmit FSM ----------------
    aer_state_t               state;
    logic                     req_q, tag_q;
    logic [AER_OUT_WIDTH-1:0] addr_q;

    // The head stays in the FIFO while it is being offered and is removed
    // only once the receiver has acknowledged it.
    assign fifo_pop = (state == ST_REQ_HI) && ack_s;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            req_q  <= 1'b0;
            tag_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {tag_q, addr_q} <= fifo_head;
                        req_q           <= 1'b1;
                        state           <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= ST_ACK_LO;
                    end
                end
                ST_ACK_LO: begin
                    if (!ack_s) state <= ST_IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign aer.AERout_REQ  = req_q;
    assign aer.AERout_TAG  = tag_q;
    assign aer.AERout_ADDR = addr_q;

endmodule
